// File: rtl/hazard_unit_p_pkg.sv
// Shared definitions for the hazard unit: forward-select encodings and the
// per-stage tracker record.
package hazard_unit_p_pkg;

    localparam logic [2:0] FWD_RF  = 3'd0;
    localparam logic [2:0] FWD_EXE = 3'd1;
    localparam logic [2:0] FWD_MEM = 3'd2;
    localparam logic [2:0] FWD_WB  = 3'd3;

    // Register indices are stored zero-extended so one record type serves any REG_AW up to this width.
    localparam int ENTRY_AW_MAX = 16;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_AW_MAX-1:0] rd;
        logic                    is_load;
    } trk_entry_t;

    function automatic logic [2:0] stage_to_fwd(input logic hit, input logic [2:0] stage);
        return hit ? (stage + 3'd1) : FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of the tracker for one ID source operand; the youngest
// (lowest stage index) matching writer wins.
module hazard_match
    import hazard_unit_p_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NSTG     = 3,
    parameter int LOAD_RDY = 1
) (
    input  trk_entry_t [NSTG-1:0] entries,
    input  logic [REG_AW-1:0]     src,
    input  logic                  used,
    input  logic                  id_valid,
    output logic                  hit,
    output logic [2:0]            stage,
    output logic                  unready_load
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit          = 1'b0;
        stage        = 3'd0;
        unready_load = 1'b0;
        for (int s = NSTG - 1; s >= 0; s--) begin
            if (id_valid && used && (src != {REG_AW{1'b0}}) && entries[s].valid &&
                (entries[s].rd == ENTRY_AW_MAX'(src))) begin
                hit          = 1'b1;
                stage        = 3'(s);
                unready_load = entries[s].is_load && (s < LOAD_RDY);
            end else begin
                hit          = hit;
            end
        end
    end

endmodule

// File: rtl/hazard_unit_p.sv
// Load-use hazard detection and forwarding-select generation for an in-order
// pipeline, with a stall counter.
module hazard_unit_p
    import hazard_unit_p_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NSTG     = 3,
    parameter int LOAD_RDY = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_kill,
    input  logic              ext_stall,
    output logic [2:0]        fwd_rs,
    output logic [2:0]        fwd_rt,
    output logic              stall_id,
    output logic [CNT_W-1:0]  stall_cnt
);

    trk_entry_t [NSTG-1:0] trk_r;
    logic                  rs_hit_s, rt_hit_s;
    logic [2:0]            rs_stage_s, rt_stage_s;
    logic                  rs_unready_s, rt_unready_s;
    logic                  enter_s;

    hazard_match #(.REG_AW(REG_AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY)) u_match_rs (
        .entries      (trk_r),
        .src          (id_rs),
        .used         (id_rs_used),
        .id_valid     (id_valid),
        .hit          (rs_hit_s),
        .stage        (rs_stage_s),
        .unready_load (rs_unready_s)
    );

    hazard_match #(.REG_AW(REG_AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY)) u_match_rt (
        .entries      (trk_r),
        .src          (id_rt),
        .used         (id_rt_used),
        .id_valid     (id_valid),
        .hit          (rt_hit_s),
        .stage        (rt_stage_s),
        .unready_load (rt_unready_s)
    );

    // Outputs are combinational from tracker state and ID inputs (zero latency).
    always_comb begin
        fwd_rs   = stage_to_fwd(rs_hit_s, rs_stage_s);
        fwd_rt   = stage_to_fwd(rt_hit_s, rt_stage_s);
        stall_id = !id_kill && (rs_unready_s || rt_unready_s);
        enter_s  = !stall_id && id_valid && !id_kill && id_regwrite &&
                   (id_rd != {REG_AW{1'b0}});
    end

    // Tracker shift and stall counter; everything freezes while ext_stall is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTG; s++) begin
                trk_r[s].valid <= 1'b0;
            end
            stall_cnt <= {CNT_W{1'b0}};
        end else if (!ext_stall) begin
            for (int s = NSTG - 1; s > 0; s--) begin
                trk_r[s] <= trk_r[s-1];
            end
            trk_r[0].valid   <= enter_s;
            trk_r[0].rd      <= ENTRY_AW_MAX'(id_rd);
            trk_r[0].is_load <= id_memread;
            if (stall_id && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
        end else begin
            trk_r     <= trk_r;
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: default instance plus NSTG=4/LOAD_RDY=2/CNT_W=3
// instance, both checked against an instruction-level pipeline model.
module tb_hazard_unit_p;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, id_kill, ext_stall;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [2:0] fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b;
    logic       stall_id_a, stall_id_b;
    logic [15:0] stall_cnt_a;
    logic [2:0]  stall_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit_p dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_kill(id_kill),
        .ext_stall(ext_stall), .fwd_rs(fwd_rs_a), .fwd_rt(fwd_rt_a),
        .stall_id(stall_id_a), .stall_cnt(stall_cnt_a)
    );

    hazard_unit_p #(.NSTG(4), .LOAD_RDY(2), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_kill(id_kill),
        .ext_stall(ext_stall), .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b),
        .stall_id(stall_id_b), .stall_cnt(stall_cnt_b)
    );

    // Reference model: which instruction sits in which post-ID stage.
    bit mv  [2][8];
    int mrd [2][8];
    bit mld [2][8];
    int mcnt[2];
    int nst [2] = '{3, 4};
    int lrd [2] = '{1, 2};
    int cmax[2] = '{65535, 7};

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_src(input int k, input int src, input bit used,
                                      output int fwd, output bit unr);
        fwd = 0;
        unr = 1'b0;
        if (id_valid && used && src != 0) begin
            for (int s = 0; s < nst[k]; s++) begin
                if (mv[k][s] && mrd[k][s] == src) begin
                    fwd = s + 1;
                    unr = mld[k][s] && (s < lrd[k]);
                    break;
                end
            end
        end
    endfunction

    task automatic drive(input int v, input int rs, input int rsu, input int rt, input int rtu,
                         input int rd, input int rw, input int mr, input int kill, input int ext);
        id_valid    = (v != 0);
        id_rs       = 5'(rs);
        id_rs_used  = (rsu != 0);
        id_rt       = 5'(rt);
        id_rt_used  = (rtu != 0);
        id_rd       = 5'(rd);
        id_regwrite = (rw != 0);
        id_memread  = (mr != 0);
        id_kill     = (kill != 0);
        ext_stall   = (ext != 0);
    endtask

    // Check both instances against the model, then advance model and DUT one clock.
    task automatic cycle();
        int e_rs, e_rt;
        bit u_rs, u_rt, e_st;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_src(k, int'(id_rs), id_rs_used, e_rs, u_rs);
            model_src(k, int'(id_rt), id_rt_used, e_rt, u_rt);
            e_st = !id_kill && (u_rs || u_rt);
            chk($sformatf("fwd_rs_i%0d", k), int'(k == 0 ? fwd_rs_a : fwd_rs_b), e_rs);
            chk($sformatf("fwd_rt_i%0d", k), int'(k == 0 ? fwd_rt_a : fwd_rt_b), e_rt);
            chk($sformatf("stall_i%0d", k), int'(k == 0 ? stall_id_a : stall_id_b), int'(e_st));
            chk($sformatf("cnt_i%0d", k), (k == 0 ? int'(stall_cnt_a) : int'(stall_cnt_b)), mcnt[k]);
            if (rst) begin
                for (int s = 0; s < 8; s++) mv[k][s] = 1'b0;
                mcnt[k] = 0;
            end else if (!ext_stall) begin
                for (int s = nst[k] - 1; s > 0; s--) begin
                    mv[k][s]  = mv[k][s-1];
                    mrd[k][s] = mrd[k][s-1];
                    mld[k][s] = mld[k][s-1];
                end
                mv[k][0]  = !e_st && id_valid && !id_kill && id_regwrite && (id_rd != 5'd0);
                mrd[k][0] = int'(id_rd);
                mld[k][0] = id_memread;
                if (e_st && mcnt[k] < cmax[k]) mcnt[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            for (int s = 0; s < 8; s++) begin
                mv[k][s] = 1'b0; mrd[k][s] = 0; mld[k][s] = 1'b0;
            end
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        do_reset();
        #1;
        chk("rst_fwd_rs", int'(fwd_rs_a), 0);
        chk("rst_stall", int'(stall_id_a), 0);

        // add $3 in EXE, ID reads $3
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cycle();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("add_fwd_rs", int'(fwd_rs_a), 1);
        chk("add_stall", int'(stall_id_a), 0);
        cycle();

        // two writers of $7; youngest (EXE) wins
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle(); cycle();
        drive(1, 7, 1, 7, 1, 0, 0, 0, 0, 0); #1;
        chk("dual_fwd_rs", int'(fwd_rs_a), 1);
        chk("dual_fwd_rt", int'(fwd_rt_a), 1);
        cycle();

        // writes to $0 are never tracked
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); #1;
        chk("zero_fwd_rs", int'(fwd_rs_a), 0);
        chk("zero_stall", int'(stall_id_a), 0);
        cycle();

        // load-use: one stall, then forward from MEM
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); #1;
        chk("lu_stall", int'(stall_id_a), 1);
        chk("lu_cnt0", int'(stall_cnt_a), 0);
        cycle();
        chk("lu_cnt1", int'(stall_cnt_a), 1);
        chk("lu_stall2", int'(stall_id_a), 0);
        chk("lu_fwd_rt", int'(fwd_rt_a), 2);
        cycle();

        // external stall freezes tracker and counter
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ext_stall_held", int'(stall_id_a), 1);
            chk("ext_cnt_held", int'(stall_cnt_a), 0);
            cycle();
        end
        ext_stall = 1'b0;
        cycle();
        chk("ext_cnt_after", int'(stall_cnt_a), 1);
        chk("ext_fwd_rt", int'(fwd_rt_a), 2);
        cycle();

        // reset mid-stall drops the pending load
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); cycle();
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); rst = 1'b1; cycle();
        rst = 1'b0; #1;
        chk("rstmid_stall", int'(stall_id_a), 0);
        chk("rstmid_fwd_rt", int'(fwd_rt_a), 0);
        cycle();

        // deep pipeline: two stalls, kill during stall, then forward from WB
        do_reset();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); cycle();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("deep_stall1", int'(stall_id_b), 1);
        cycle();
        chk("deep_stall2", int'(stall_id_b), 1);
        id_kill = 1'b1; #1;
        chk("deep_kill", int'(stall_id_b), 0);
        cycle();
        id_kill = 1'b0; #1;
        chk("deep_fwd_rs", int'(fwd_rs_b), 3);
        chk("deep_stall3", int'(stall_id_b), 0);
        cycle();

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 8) != 0, $urandom % 8, $urandom % 4 != 0, $urandom % 8,
                  $urandom % 4 != 0, $urandom % 8, $urandom % 4 != 0, $urandom % 2,
                  ($urandom % 12) == 0, ($urandom % 5) == 0);
            rst = (($urandom % 80) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
